// File: rtl/doorlock_pkg.sv
// rtl/doorlock_pkg.sv - LED pattern codes and scheduler state encoding shared by the door-lock LED path
package doorlock_pkg;

   localparam logic [1:0] LED_OFF   = 2'd0;
   localparam logic [1:0] LED_KEY   = 2'd1;
   localparam logic [1:0] LED_OK    = 2'd2;
   localparam logic [1:0] LED_ALARM = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } sched_state_t;

endpackage

// File: rtl/led_hold_cnt.sv
// rtl/led_hold_cnt.sv - loadable hold down-counter that saturates at zero
module led_hold_cnt #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/led_sig_sched.sv
// rtl/led_sig_sched.sv - priority scheduler sharing the led_sig channel between key, OK and alarm patterns
module led_sig_sched
   import doorlock_pkg::*;
#(
   parameter int KEY_TICKS   = 3,
   parameter int OK_TICKS    = 20,
   parameter int ALARM_TICKS = 50,
   parameter int CNT_W       = 6
) (
   input  logic       clk_10hz_i,
   input  logic       rst_i,
   input  logic       key_req_i,
   input  logic       ok_req_i,
   input  logic       alarm_req_i,
   input  logic       alarm_clr_i,
   output logic       key_ack_o,
   output logic       ok_ack_o,
   output logic       alarm_ack_o,
   output logic [1:0] led_sig_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam logic [CNT_W-1:0] KEY_LOAD   = CNT_W'(KEY_TICKS - 1);
   localparam logic [CNT_W-1:0] OK_LOAD    = CNT_W'(OK_TICKS - 1);
   localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TICKS - 1);

   sched_state_t     state;
   logic             pend_key, pend_ok, pend_alarm;
   logic             alarm_live;
   logic             grant_key, grant_ok, grant_alarm, grant_any;
   logic             finish;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic [1:0]       grant_code;

   // A clear on the same edge cancels a pending alarm before it can be granted.
   assign alarm_live = pend_alarm && !alarm_clr_i;

   always_comb begin
      grant_key    = 1'b0;
      grant_ok     = 1'b0;
      grant_alarm  = 1'b0;
      finish       = 1'b0;
      cnt_dec      = 1'b0;
      if (state == ST_IDLE) begin
         if (alarm_live)    grant_alarm = 1'b1;
         else if (pend_ok)  grant_ok    = 1'b1;
         else if (pend_key) grant_key   = 1'b1;
      end else begin
         if (alarm_clr_i && (led_sig_o == LED_ALARM)) finish      = 1'b1;
         else if (alarm_live)                         grant_alarm = 1'b1;
         else if (cnt_zero)                           finish      = 1'b1;
         else                                         cnt_dec     = 1'b1;
      end
   end

   always_comb begin
      grant_code   = LED_KEY;
      cnt_load_val = KEY_LOAD;
      if (grant_alarm) begin
         grant_code   = LED_ALARM;
         cnt_load_val = ALARM_LOAD;
      end else if (grant_ok) begin
         grant_code   = LED_OK;
         cnt_load_val = OK_LOAD;
      end
   end

   assign grant_any = grant_key || grant_ok || grant_alarm;
   assign cnt_load  = grant_any;

   led_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk      (clk_10hz_i),
      .rst_n    (rst_i),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk_10hz_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= ST_IDLE;
         pend_key    <= 1'b0;
         pend_ok     <= 1'b0;
         pend_alarm  <= 1'b0;
         key_ack_o   <= 1'b0;
         ok_ack_o    <= 1'b0;
         alarm_ack_o <= 1'b0;
         led_sig_o   <= LED_OFF;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         // A request arriving on the granting edge survives the grant.
         pend_key    <= (pend_key && !grant_key) || key_req_i;
         pend_ok     <= (pend_ok && !grant_ok) || ok_req_i;
         pend_alarm  <= !alarm_clr_i && ((pend_alarm && !grant_alarm) || alarm_req_i);
         key_ack_o   <= grant_key;
         ok_ack_o    <= grant_ok;
         alarm_ack_o <= grant_alarm;
         done_o      <= finish;
         if (grant_any) begin
            state     <= ST_SHOW;
            led_sig_o <= grant_code;
            busy_o    <= 1'b1;
         end else if (finish) begin
            state     <= ST_IDLE;
            led_sig_o <= LED_OFF;
            busy_o    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_led_sig_sched.sv
// tb/tb_led_sig_sched.sv - directed self-checking bench for led_sig_sched
module tb_led_sig_sched;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       key_req_i = 1'b0, ok_req_i = 1'b0, alarm_req_i = 1'b0, alarm_clr_i = 1'b0;
   logic       key_ack_o, ok_ack_o, alarm_ack_o, busy_o, done_o;
   logic [1:0] led_sig_o;

   int n_checks = 0;
   int n_fail   = 0;

   led_sig_sched dut (
      .clk_10hz_i  (clk),
      .rst_i       (rst_i),
      .key_req_i   (key_req_i),
      .ok_req_i    (ok_req_i),
      .alarm_req_i (alarm_req_i),
      .alarm_clr_i (alarm_clr_i),
      .key_ack_o   (key_ack_o),
      .ok_ack_o    (ok_ack_o),
      .alarm_ack_o (alarm_ack_o),
      .led_sig_o   (led_sig_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks led_sig_o on the current cycle, then advances, n times.
   task automatic expect_hold(input string tag, input logic [1:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         chk_eq(tag, {30'd0, led_sig_o}, {30'd0, code});
         chk_eq({tag, "_nodone"}, {31'd0, done_o}, 32'd0);
         tick();
      end
   endtask

   task automatic chk_acks(input string tag, input logic k, input logic o, input logic a);
      chk_eq({tag, "_key_ack"}, {31'd0, key_ack_o}, {31'd0, k});
      chk_eq({tag, "_ok_ack"}, {31'd0, ok_ack_o}, {31'd0, o});
      chk_eq({tag, "_alarm_ack"}, {31'd0, alarm_ack_o}, {31'd0, a});
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk_eq("rst_led", {30'd0, led_sig_o}, 32'd0);
      chk_eq("rst_busy", {31'd0, busy_o}, 32'd0);
      chk_eq("rst_done", {31'd0, done_o}, 32'd0);
      chk_acks("rst", 1'b0, 1'b0, 1'b0);
      rst_i = 1'b1;
      tick(); tick();

      // 1: single key request, 3-cycle hold, done with OFF
      key_req_i = 1'b1; tick(); key_req_i = 1'b0;
      chk_eq("t1_pend_led", {30'd0, led_sig_o}, 32'd0);
      chk_acks("t1_pend", 1'b0, 1'b0, 1'b0);
      tick();
      chk_acks("t1_grant", 1'b1, 1'b0, 1'b0);
      chk_eq("t1_busy", {31'd0, busy_o}, 32'd1);
      expect_hold("t1_key", 2'd1, 3);
      chk_eq("t1_off", {30'd0, led_sig_o}, 32'd0);
      chk_eq("t1_done", {31'd0, done_o}, 32'd1);
      tick();
      chk_eq("t1_done_pulse", {31'd0, done_o}, 32'd0);
      chk_eq("t1_idle_busy", {31'd0, busy_o}, 32'd0);
      tick();

      // 2: all three at once -> ALARM, OK, KEY with OFF gaps
      key_req_i = 1'b1; ok_req_i = 1'b1; alarm_req_i = 1'b1; tick();
      key_req_i = 1'b0; ok_req_i = 1'b0; alarm_req_i = 1'b0;
      tick();
      chk_acks("t2_a", 1'b0, 1'b0, 1'b1);
      expect_hold("t2_alarm", 2'd3, 50);
      chk_eq("t2_gap1", {30'd0, led_sig_o}, 32'd0);
      chk_eq("t2_done1", {31'd0, done_o}, 32'd1);
      tick();
      chk_acks("t2_o", 1'b0, 1'b1, 1'b0);
      expect_hold("t2_ok", 2'd2, 20);
      chk_eq("t2_gap2", {30'd0, led_sig_o}, 32'd0);
      chk_eq("t2_done2", {31'd0, done_o}, 32'd1);
      tick();
      chk_acks("t2_k", 1'b1, 1'b0, 1'b0);
      expect_hold("t2_key", 2'd1, 3);
      chk_eq("t2_done3", {31'd0, done_o}, 32'd1);
      tick();
      chk_eq("t2_idle", {31'd0, busy_o}, 32'd0);
      chk_acks("t2_idle", 1'b0, 1'b0, 1'b0);

      // 3: alarm preempts OK; OK dropped, not resumed
      ok_req_i = 1'b1; tick(); ok_req_i = 1'b0;
      tick();
      chk_acks("t3_o", 1'b0, 1'b1, 1'b0);
      expect_hold("t3_ok", 2'd2, 5);
      alarm_req_i = 1'b1;
      chk_eq("t3_ok_still", {30'd0, led_sig_o}, 32'd2);
      tick(); alarm_req_i = 1'b0;
      chk_eq("t3_ok_edge1", {30'd0, led_sig_o}, 32'd2);
      tick();
      chk_acks("t3_pre", 1'b0, 1'b0, 1'b1);
      expect_hold("t3_alarm", 2'd3, 50);
      chk_eq("t3_done", {31'd0, done_o}, 32'd1);
      chk_eq("t3_off", {30'd0, led_sig_o}, 32'd0);
      tick();
      chk_eq("t3_no_resume", {30'd0, led_sig_o}, 32'd0);
      chk_acks("t3_after", 1'b0, 1'b0, 1'b0);
      tick();
      chk_eq("t3_no_resume2", {31'd0, busy_o}, 32'd0);

      // 4: alarm re-trigger at cycle 30 restarts the 50-cycle hold
      alarm_req_i = 1'b1; tick(); alarm_req_i = 1'b0;
      tick();
      chk_acks("t4_a1", 1'b0, 1'b0, 1'b1);
      expect_hold("t4_first", 2'd3, 30);
      alarm_req_i = 1'b1; tick(); alarm_req_i = 1'b0;
      chk_eq("t4_mid", {30'd0, led_sig_o}, 32'd3);
      chk_acks("t4_mid", 1'b0, 1'b0, 1'b0);
      tick();
      chk_acks("t4_a2", 1'b0, 1'b0, 1'b1);
      expect_hold("t4_second", 2'd3, 50);
      chk_eq("t4_done", {31'd0, done_o}, 32'd1);
      chk_eq("t4_off", {30'd0, led_sig_o}, 32'd0);
      tick(); tick();

      // 5: alarm clear while active; clear+request together in IDLE
      alarm_req_i = 1'b1; tick(); alarm_req_i = 1'b0;
      tick();
      chk_acks("t5_a", 1'b0, 1'b0, 1'b1);
      expect_hold("t5_alarm", 2'd3, 4);
      alarm_clr_i = 1'b1; tick(); alarm_clr_i = 1'b0;
      chk_eq("t5_clr_led", {30'd0, led_sig_o}, 32'd0);
      chk_eq("t5_clr_done", {31'd0, done_o}, 32'd1);
      chk_eq("t5_clr_busy", {31'd0, busy_o}, 32'd0);
      tick();
      chk_eq("t5_done_pulse", {31'd0, done_o}, 32'd0);
      alarm_clr_i = 1'b1; alarm_req_i = 1'b1; tick();
      alarm_clr_i = 1'b0; alarm_req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_acks("t5_nogrant", 1'b0, 1'b0, 1'b0);
         chk_eq("t5_nogrant_led", {30'd0, led_sig_o}, 32'd0);
      end

      // 6: asynchronous reset mid-OK with a key pending
      ok_req_i = 1'b1; tick(); ok_req_i = 1'b0;
      tick();
      chk_acks("t6_o", 1'b0, 1'b1, 1'b0);
      key_req_i = 1'b1;
      expect_hold("t6_ok", 2'd2, 1);
      key_req_i = 1'b0;
      expect_hold("t6_ok", 2'd2, 9);
      #3 rst_i = 1'b0;
      #1;
      chk_eq("t6_rst_led", {30'd0, led_sig_o}, 32'd0);
      chk_eq("t6_rst_busy", {31'd0, busy_o}, 32'd0);
      chk_eq("t6_rst_done", {31'd0, done_o}, 32'd0);
      chk_acks("t6_rst", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_acks("t6_stale", 1'b0, 1'b0, 1'b0);
         chk_eq("t6_stale_led", {30'd0, led_sig_o}, 32'd0);
         chk_eq("t6_stale_done", {31'd0, done_o}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
